// File: rtl/k_and_s_pkg.sv
// Shared encodings for the K&S processor control path: decoded instruction
// set, control FSM states, ALU operation codes and the bundled strobe set
// that the control unit drives toward the datapath.
package k_and_s_pkg;

  // Instruction classes produced by the datapath's IR decoder.
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;

  // Control FSM states.
  typedef enum logic [2:0] {
    S_FETCH       = 3'd0,
    S_DECODE      = 3'd1,
    S_EXEC_LOAD   = 3'd2,
    S_EXEC_STORE  = 3'd3,
    S_EXEC_MOVE   = 3'd4,
    S_EXEC_ALU    = 3'd5,
    S_EXEC_BRANCH = 3'd6,
    S_HALTED      = 3'd7
  } ctrl_state_t;

  // ALU operation select codes.
  localparam logic [1:0] ALU_OR  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  // Full set of control outputs, kept together so one default covers all.
  typedef struct packed {
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       write_reg_enable;
    logic       flags_reg_enable;
    logic       ram_write_enable;
    logic       halt;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_IDLE = '0;

  // ALU code for an arithmetic/logic instruction; OR for anything else.
  function automatic logic [1:0] alu_op_of(input decoded_instruction_type instr);
    logic [1:0] op;
    op = ALU_OR;
    case (instr)
      I_ADD:   op = ALU_ADD;
      I_SUB:   op = ALU_SUB;
      I_AND:   op = ALU_AND;
      default: op = ALU_OR;
    endcase
    return op;
  endfunction

  // Whether a branch instruction is taken given the committed flags.
  // BOV/BNOV look at the unsigned overflow flag only.
  function automatic logic branch_taken(input decoded_instruction_type instr,
                                        input logic zero_op,
                                        input logic neg_op,
                                        input logic unsigned_overflow);
    logic taken;
    taken = 1'b0;
    case (instr)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero_op;
      I_BNZERO: taken = ~zero_op;
      I_BNEG:   taken = neg_op;
      I_BNNEG:  taken = ~neg_op;
      I_BOV:    taken = unsigned_overflow;
      I_BNOV:   taken = ~unsigned_overflow;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control/datapath link: decode and flags travel from the datapath (master)
// to the control unit (slave); strobes and selects travel back.
interface control_unit_if;
  import k_and_s_pkg::*;

  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;

  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    addr_sel;
  logic                    c_sel;
  logic [1:0]              operation;
  logic                    write_reg_enable;
  logic                    flags_reg_enable;
  logic                    ram_write_enable;
  logic                    halt;

  // Datapath side.
  modport master (
    output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt
  );

  // Control unit side.
  modport slave (
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt
  );

endinterface

// File: rtl/control_unit.sv
// K&S control unit: multi-cycle FETCH/DECODE/EXEC sequencer with Moore
// outputs. A run flag, cleared asynchronously by reset, holds every output
// at zero until the first rising edge after reset release, so the first
// FETCH cycle starts on that edge and a reset pulse silences strobes at once.
module control_unit
  import k_and_s_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  control_unit_if.slave cu
);

  ctrl_state_t state_reg;
  ctrl_state_t state_next;
  logic        run_reg;
  ctrl_out_t   out;

  // State register and run flag; reset forces FETCH without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      run_reg   <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (run_reg) begin
        state_reg <= state_next;
      end
    end
  end

  // Next-state decision; DECODE dispatches on the settled instruction.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (cu.decoded_instruction)
          I_LOAD:   state_next = S_EXEC_LOAD;
          I_STORE:  state_next = S_EXEC_STORE;
          I_MOVE:   state_next = S_EXEC_MOVE;
          I_ADD, I_SUB, I_AND, I_OR:
                    state_next = S_EXEC_ALU;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                    state_next = S_EXEC_BRANCH;
          I_HALT:   state_next = S_HALTED;
          default:  state_next = S_FETCH;
        endcase
      end
      S_EXEC_LOAD,
      S_EXEC_STORE,
      S_EXEC_MOVE,
      S_EXEC_ALU,
      S_EXEC_BRANCH: state_next = S_FETCH;
      S_HALTED:      state_next = S_HALTED;
      default:       state_next = S_FETCH;
    endcase
  end

  // Output decode from state (plus instruction/flags in EXEC states).
  always_comb begin
    out = CTRL_IDLE;
    if (run_reg) begin
      case (state_reg)
        S_FETCH: begin
          out.addr_sel  = 1'b0;
          out.ir_enable = 1'b1;
        end
        S_DECODE: begin
          out.pc_enable = 1'b1;
          out.branch    = 1'b0;
        end
        S_EXEC_LOAD: begin
          out.addr_sel         = 1'b1;
          out.c_sel            = 1'b0;
          out.write_reg_enable = 1'b1;
        end
        S_EXEC_STORE: begin
          out.addr_sel         = 1'b1;
          out.ram_write_enable = 1'b1;
        end
        S_EXEC_MOVE: begin
          // MOVE passes the operand through the ALU as an OR with zero
          // and must leave the flags untouched.
          out.operation        = ALU_OR;
          out.c_sel            = 1'b1;
          out.write_reg_enable = 1'b1;
          out.flags_reg_enable = 1'b0;
        end
        S_EXEC_ALU: begin
          out.operation        = alu_op_of(cu.decoded_instruction);
          out.c_sel            = 1'b1;
          out.write_reg_enable = 1'b1;
          out.flags_reg_enable = 1'b1;
        end
        S_EXEC_BRANCH: begin
          // A target equal to PC+1 is simply loaded like any other target.
          if (branch_taken(cu.decoded_instruction, cu.zero_op, cu.neg_op,
                           cu.unsigned_overflow)) begin
            out.pc_enable = 1'b1;
            out.branch    = 1'b1;
          end
        end
        S_HALTED: begin
          out.halt = 1'b1;
        end
        default: out = CTRL_IDLE;
      endcase
    end
  end

  assign cu.branch           = out.branch;
  assign cu.pc_enable        = out.pc_enable;
  assign cu.ir_enable        = out.ir_enable;
  assign cu.addr_sel         = out.addr_sel;
  assign cu.c_sel            = out.c_sel;
  assign cu.operation        = out.operation;
  assign cu.write_reg_enable = out.write_reg_enable;
  assign cu.flags_reg_enable = out.flags_reg_enable;
  assign cu.ram_write_enable = out.ram_write_enable;
  assign cu.halt             = out.halt;

  // signed_overflow is carried on the link but no branch condition uses it.
  logic unused_ok;
  assign unused_ok = cu.signed_overflow;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the stimulus pushes the expected output
// vector of every cycle into a queue; a monitor pops and compares on each
// falling clock edge, or immediately on request for asynchronous checks.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk;
  logic rst_n;
  control_unit_if bus ();

  control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cu    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [10:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  event sample_req;

  // Vector order: halt branch pc_en ir_en addr_sel c_sel op[1:0] wr_en fl_en ram_we
  function automatic logic [10:0] ev(input logic h, input logic br, input logic pc,
                                     input logic ir, input logic ad, input logic cs,
                                     input logic [1:0] op, input logic wr,
                                     input logic fl, input logic rw);
    return {h, br, pc, ir, ad, cs, op, wr, fl, rw};
  endfunction

  logic [10:0] E_ZERO, E_FETCH, E_DECODE, E_LOAD, E_STORE, E_MOVE, E_BR_T, E_HALT;

  function automatic logic [10:0] e_alu(input logic [1:0] op);
    return ev(0, 0, 0, 0, 0, 1, op, 1, 1, 0);
  endfunction

  function automatic logic [10:0] dut_vec();
    return {bus.halt, bus.branch, bus.pc_enable, bus.ir_enable, bus.addr_sel,
            bus.c_sel, bus.operation, bus.write_reg_enable, bus.flags_reg_enable,
            bus.ram_write_enable};
  endfunction

  // Monitor: compare whatever expectation is pending at each sample point.
  initial begin
    sb_t         e;
    logic [10:0] got;
    forever begin
      @(negedge clk or sample_req);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = dut_vec();
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL %s: got=%b expected=%b (h br pc ir ad cs op wr fl rw)",
                   e.name, got, e.exp);
        end else begin
          $display("ok   %s: %b", e.name, got);
        end
      end
    end
  end

  // One clock cycle: expectation for the state entered at this rising edge.
  task automatic cyc(input string name, input logic [10:0] exp);
    sb_t e;
    @(posedge clk);
    #1;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Push an expectation and have it checked now, away from any clock edge.
  task automatic check_now(input string name, input logic [10:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    -> sample_req;
    #0;
  endtask

  // Full instruction: FETCH, DECODE, optional EXEC cycle.
  task automatic run_instr(input string name, input decoded_instruction_type instr,
                           input logic z, input logic n, input logic uo,
                           input logic has_exec, input logic [10:0] exec_exp);
    cyc({name, "_fetch"}, E_FETCH);
    bus.decoded_instruction = instr;
    bus.zero_op             = z;
    bus.neg_op              = n;
    bus.unsigned_overflow   = uo;
    cyc({name, "_decode"}, E_DECODE);
    if (has_exec) cyc({name, "_exec"}, exec_exp);
  endtask

  initial begin
    E_ZERO   = ev(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    E_FETCH  = ev(0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
    E_DECODE = ev(0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0);
    E_LOAD   = ev(0, 0, 0, 0, 1, 0, 2'b00, 1, 0, 0);
    E_STORE  = ev(0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 1);
    E_MOVE   = ev(0, 0, 0, 0, 0, 1, 2'b00, 1, 0, 0);
    E_BR_T   = ev(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0);
    E_HALT   = ev(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);

    rst_n                   = 1'b0;
    bus.decoded_instruction = I_NOP;
    bus.zero_op             = 1'b0;
    bus.neg_op              = 1'b0;
    bus.unsigned_overflow   = 1'b0;
    bus.signed_overflow     = 1'b0;

    // Held in reset: everything low.
    cyc("reset0", E_ZERO);
    cyc("reset1", E_ZERO);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // ALU and memory instructions.
    run_instr("add",   I_ADD,   0, 0, 0, 1, e_alu(2'b01));
    run_instr("load",  I_LOAD,  0, 0, 0, 1, E_LOAD);
    run_instr("store", I_STORE, 0, 0, 0, 1, E_STORE);
    run_instr("move",  I_MOVE,  0, 0, 0, 1, E_MOVE);
    run_instr("sub",   I_SUB,   0, 0, 0, 1, e_alu(2'b10));
    run_instr("and",   I_AND,   0, 0, 0, 1, e_alu(2'b11));
    run_instr("or",    I_OR,    0, 0, 0, 1, e_alu(2'b00));

    // Conditional branches, taken and not taken.
    run_instr("bzero_t",  I_BZERO,  1, 0, 0, 1, E_BR_T);
    run_instr("bzero_nt", I_BZERO,  0, 0, 0, 1, E_ZERO);
    run_instr("bnov_t",   I_BNOV,   0, 0, 0, 1, E_BR_T);
    run_instr("bnov_nt",  I_BNOV,   0, 0, 1, 1, E_ZERO);
    run_instr("bneg_t",   I_BNEG,   0, 1, 0, 1, E_BR_T);
    run_instr("bnneg_nt", I_BNNEG,  0, 1, 0, 1, E_ZERO);
    run_instr("bov_t",    I_BOV,    0, 0, 1, 1, E_BR_T);
    run_instr("bnzero_t", I_BNZERO, 0, 0, 0, 1, E_BR_T);
    run_instr("branch",   I_BRANCH, 0, 0, 0, 1, E_BR_T);

    // NOP takes two cycles; the next FETCH follows DECODE directly.
    run_instr("nop", I_NOP, 0, 0, 0, 0, E_ZERO);

    // Reset pulse in the middle of EXEC_ALU.
    run_instr("add_rst", I_ADD, 0, 0, 0, 1, e_alu(2'b01));
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_now("alu_async_rst", E_ZERO);
    cyc("alu_rst_hold", E_ZERO);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_instr("post_rst", I_STORE, 0, 0, 0, 1, E_STORE);

    // HALT holds for 20 cycles; only reset leaves it.
    cyc("halt_fetch", E_FETCH);
    bus.decoded_instruction = I_HALT;
    cyc("halt_decode", E_DECODE);
    for (int i = 0; i < 20; i++) cyc($sformatf("halted%0d", i), E_HALT);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_now("halt_async_rst", E_ZERO);
    cyc("halt_rst_hold", E_ZERO);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_instr("after_halt", I_ADD, 0, 0, 0, 1, e_alu(2'b01));

    // Let the monitor drain, then confirm nothing was left unchecked.
    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: pending=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; all encodings SHALL come from k_and_s_pkg.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 decoded_instruction  input  decoded_instruction_type  current IR decode from the datapath.
REQ-005 zero_op, neg_op, unsigned_overflow, signed_overflow  input  1 each  registered flags from the datapath.
REQ-006 branch  output  1  PC load select: 1 = mem_addr, 0 = PC+1.
REQ-007 pc_enable  output  1  PC update strobe.
REQ-008 ir_enable  output  1  IR load strobe.
REQ-009 addr_sel  output  1  RAM address select: 1 = mem_addr, 0 = PC.
REQ-010 c_sel  output  1  register write source: 1 = ALU, 0 = data_in.
REQ-011 operation  output  2  ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND.
REQ-012 write_reg_enable  output  1  register bank write strobe.
REQ-013 flags_reg_enable  output  1  flag register update strobe.
REQ-014 ram_write_enable  output  1  RAM write strobe (STORE).
REQ-015 halt  output  1  high while halted.

Function
REQ-016 FSM states: FETCH, DECODE, EXEC_LOAD, EXEC_STORE, EXEC_MOVE, EXEC_ALU, EXEC_BRANCH, HALTED.
REQ-017 Outputs are Moore-decoded from state plus decoded_instruction/flags; every strobe not listed for a state SHALL be 0, addr_sel 0, c_sel 0, operation 00.
REQ-018 FETCH: addr_sel=0, ir_enable=1; next DECODE.
REQ-019 DECODE: pc_enable=1, branch=0 (PC <- PC+1); one cycle so the registered operand buses settle; next state by instruction: LOAD->EXEC_LOAD, STORE->EXEC_STORE, MOVE->EXEC_MOVE, ADD/SUB/AND/OR->EXEC_ALU, BRANCH/BZERO/BNZERO/BNEG/BNNEG/BOV/BNOV->EXEC_BRANCH, HALT->HALTED, NOP or unknown->FETCH.
REQ-020 EXEC_LOAD: addr_sel=1, c_sel=0, write_reg_enable=1; next FETCH.
REQ-021 EXEC_STORE: addr_sel=1, ram_write_enable=1; next FETCH.
REQ-022 EXEC_MOVE: operation=00, c_sel=1, write_reg_enable=1, flags_reg_enable=0; next FETCH.
REQ-023 EXEC_ALU: operation per instruction (ADD 01, SUB 10, AND 11, OR 00), c_sel=1, write_reg_enable=1, flags_reg_enable=1; next FETCH.
REQ-024 EXEC_BRANCH: taken condition BRANCH=1, BZERO=zero_op, BNZERO=!zero_op, BNEG=neg_op, BNNEG=!neg_op, BOV=unsigned_overflow, BNOV=!unsigned_overflow; if taken pc_enable=1, branch=1, else no strobes; next FETCH.
REQ-025 HALTED: halt=1, all strobes 0; remains until rst_n asserted.
REQ-026 Latency: LOAD/STORE/MOVE/ALU/BRANCH = 3 cycles, NOP = 2 cycles, fetch to fetch.
REQ-027 Flags sampled in EXEC_BRANCH are those committed by the most recent EXEC_ALU; flags SHALL NOT change in any other state.
REQ-028 Branch target equal to current PC+1 is legal and behaves as a normal taken branch.

Reset
REQ-029 rst_n low SHALL force state FETCH immediately, independent of clk, including mid-instruction and from HALTED.
REQ-030 During reset all outputs 0 (halt 0); first FETCH cycle begins on the first rising edge after rst_n deasserts.

Structure
REQ-031 k_and_s_pkg SHALL hold decoded_instruction_type, a new ctrl_state_t enum, and ALU op constants (ALU_OR, ALU_ADD, ALU_SUB, ALU_AND).
REQ-032 Single module: one state register process, one next-state/output combinational process; no sub-module.

Verification
REQ-033 Reset then ADD R1=R2+R3: FETCH(ir_enable) -> DECODE(pc_enable) -> EXEC_ALU(operation=01, c_sel=1, write_reg_enable=1, flags_reg_enable=1) -> FETCH.
REQ-034 LOAD addr 5'h1F then STORE addr 5'h00: addr_sel=1 in exec cycle; c_sel=0/write_reg_enable=1 for LOAD, ram_write_enable=1 for STORE.
REQ-035 BZERO with zero_op=1 -> pc_enable=1, branch=1; repeat with zero_op=0 -> no strobes; same pair for BNOV with unsigned_overflow 0/1.
REQ-036 HALT -> halt=1 held for 20 cycles, no strobes; rst_n low -> halt=0 asynchronously, FETCH after release.
REQ-037 rst_n pulsed low during EXEC_ALU -> write_reg_enable drops without a clock edge, next active cycle is FETCH.
REQ-038 Unknown opcode (NOP) -> FETCH, DECODE, FETCH; PC incremented exactly once.
